audio_pwm_dac: RTL

Downstream consumer of the sine generator. It produces the sample-rate strobe that drives the generator's step_in and captures the generator's signed 8-bit amplitude at a fixed delay after each strobe. It converts that amplitude to an 8-bit PWM duty and drives a 1-bit PWM pin for the board's audio low-pass filter. Duty updates are double-buffered so each change takes effect only on a PWM period boundary.

---
 rtl/audio_pwm_dac.sv | 91 +++++++++
 1 files changed

// File: rtl/audio_pwm_dac.sv
// Sample-rate strobe generator, delayed sample capture and double-buffered 8-bit PWM
// audio DAC. Duty changes only take effect on a PWM period boundary.
module audio_pwm_dac #(
  parameter int PERIODS_PER_SAMPLE = 32,
  parameter int CAPTURE_DELAY      = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic signed [7:0] sample_in,
  input  logic              mute_in,
  output logic              step_out,
  output logic              captured_out,
  output logic              pwm_out
);

  localparam int              PW          = (PERIODS_PER_SAMPLE > 1) ? $clog2(PERIODS_PER_SAMPLE) : 1;
  localparam logic [PW-1:0]   LAST_PERIOD = PW'(PERIODS_PER_SAMPLE - 1);
  localparam logic [7:0]      DELAY       = 8'(CAPTURE_DELAY);
  localparam logic [7:0]      MIDSCALE    = 8'd128;

  logic [7:0]    pwm_cnt;
  logic [PW-1:0] period_cnt;
  logic [7:0]    dly_cnt;
  logic          dly_busy;
  logic [7:0]    pending_duty;
  logic [7:0]    active_duty;
  logic          pwm_wrap;
  logic          capture_now;

  assign pwm_wrap    = (pwm_cnt == 8'hFF);
  assign capture_now = dly_busy && (dly_cnt == DELAY);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pwm_cnt    <= '0;
      period_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (pwm_wrap) begin
        if (period_cnt == LAST_PERIOD) period_cnt <= '0;
        else                           period_cnt <= period_cnt + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) step_out <= 1'b0;
    else         step_out <= pwm_wrap && (period_cnt == LAST_PERIOD);
  end

  // dly_cnt holds 1 after the edge ending the strobe cycle; sample is taken on the
  // edge where the count has already reached CAPTURE_DELAY, so the generator's
  // two-register pipeline has settled by then.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      dly_busy     <= 1'b0;
      dly_cnt      <= '0;
      captured_out <= 1'b0;
    end else begin
      captured_out <= capture_now;
      if (step_out) begin
        dly_busy <= 1'b1;
        dly_cnt  <= 8'd1;
      end else if (capture_now) begin
        dly_busy <= 1'b0;
      end else if (dly_busy) begin
        dly_cnt <= dly_cnt + 8'd1;
      end
    end
  end

  // A capture coinciding with a load leaves the old pending value in active_duty.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pending_duty <= MIDSCALE;
      active_duty  <= MIDSCALE;
    end else begin
      if (capture_now) begin
        if (mute_in) pending_duty <= MIDSCALE;
        else         pending_duty <= {~sample_in[7], sample_in[6:0]};
      end
      if (pwm_wrap) active_duty <= pending_duty;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) pwm_out <= 1'b0;
    else         pwm_out <= (pwm_cnt < active_duty);
  end

endmodule
